// File: rtl/sd_emmc_dma_mem_reader.sv
// -----------------------------------------------------------------------------
// sd_emmc_dma_mem_reader
//
// Purpose:
//   This is the host-to-card DMA reader of an SD/eMMC host controller. It
//   fetches 512-byte blocks (128 x 32-bit words) from system memory over an
//   AXI read channel, one 4-byte single-beat read at a time. Each word goes
//   into the TX FIFO. It stops at every SDMA buffer boundary until software
//   writes a new system address. When the programmed block count has been
//   sent, it raises a completion flag.
//
// Ports:
//   clock, reset            sole clock (rising edge), synchronous active-high reset
//   init_dma_sys_addr[31:0] start / restart system address
//   buf_boundary[2:0]       boundary code, bound = 8 << code blocks
//   block_count[15:0]       number of blocks to send (when blk_count_ena=1)
//   sys_addr_changed        pulse: new system address written (boundary resume)
//   dma_ena_trans_mode      DMA enabled for this transfer
//   dir_dat_trans_mode      0 = host-to-card (the only direction handled here)
//   blk_count_ena           1 = finite transfer of block_count blocks
//   xfer_start              pulse: start transfer
//   dat_int_rst             pulse: clear completion flag
//   data_int_cc             transfer complete
//   dma_int                 boundary-stop interrupt
//   fifo_full, fifo_wr_en, fifo_wr_data[31:0]   TX FIFO write side
//   read_addr[31:0], addr_read_valid, addr_read_ready   AXI read address
//   read_data[31:0], data_read_valid, data_read_ready   AXI read data
//
// Configuration:
//   SD_DMA_BOUNDARY_INT_EN  When defined, dma_int is raised while the reader is
//                           stopped at a buffer boundary. When undefined,
//                           dma_int is tied to 0.
// -----------------------------------------------------------------------------
module sd_emmc_dma_mem_reader (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] init_dma_sys_addr,
    input  logic [2:0]  buf_boundary,
    input  logic [15:0] block_count,
    input  logic        sys_addr_changed,
    input  logic        dma_ena_trans_mode,
    input  logic        dir_dat_trans_mode,
    input  logic        blk_count_ena,
    input  logic        xfer_start,
    input  logic        dat_int_rst,
    output logic        data_int_cc,
    output logic        dma_int,
    input  logic        fifo_full,
    output logic        fifo_wr_en,
    output logic [31:0] fifo_wr_data,
    output logic [31:0] read_addr,
    output logic        addr_read_valid,
    input  logic        addr_read_ready,
    input  logic [31:0] read_data,
    input  logic        data_read_valid,
    output logic        data_read_ready
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        ADDR         = 3'd1,
        DATA         = 3'd2,
        BLK_CHECK    = 3'd3,
        NEW_SYS_ADDR = 3'd4,
        COMPLETE     = 3'd5
    } state_t;

    localparam logic [6:0] LAST_WORD = 7'd127;

    state_t      state_q, state_d;
    logic [31:0] read_addr_q, read_addr_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        cc_q, cc_d;
    logic [6:0]  word_q, word_d;
    logic [15:0] total_blk_q, total_blk_d;
    logic [10:0] bnd_blk_q, bnd_blk_d;
    // Transfer parameters captured at start; the mode inputs are not looked at again
    logic [10:0] bound_q, bound_d;
    logic [15:0] blk_cnt_q, blk_cnt_d;
    logic        cnt_ena_q, cnt_ena_d;

    logic        start_ok_s;
    logic [15:0] total_inc_s;
    logic [10:0] bnd_inc_s;

    // A start request counts only for a DMA, host-to-card transfer
    assign start_ok_s  = xfer_start & dma_ena_trans_mode & ~dir_dat_trans_mode;
    assign total_inc_s = total_blk_q + 16'd1;
    assign bnd_inc_s   = bnd_blk_q + 11'd1;

    // Next-state and datapath update for the transfer sequencer
    always_comb begin
        state_d     = state_q;
        read_addr_d = read_addr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        wr_en_d     = 1'b0;          // FIFO write is a single-cycle pulse
        wr_data_d   = wr_data_q;
        cc_d        = cc_q;
        word_d      = word_q;
        total_blk_d = total_blk_q;
        bnd_blk_d   = bnd_blk_q;
        bound_d     = bound_q;
        blk_cnt_d   = blk_cnt_q;
        cnt_ena_d   = cnt_ena_q;

        case (state_q)
            IDLE: begin
                if (start_ok_s) begin
                    read_addr_d = init_dma_sys_addr;
                    word_d      = 7'd0;
                    total_blk_d = 16'd0;
                    bnd_blk_d   = 11'd0;
                    bound_d     = 11'd8 << buf_boundary;
                    blk_cnt_d   = block_count;
                    cnt_ena_d   = blk_count_ena;
                    // A finite transfer of zero blocks finishes without touching the bus
                    if (blk_count_ena && (block_count == 16'd0)) begin
                        state_d = COMPLETE;
                        cc_d    = 1'b1;
                    end else begin
                        state_d = ADDR;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            ADDR: begin
                if (arvalid_q) begin
                    // Valid is held, with the address stable, until it is accepted
                    if (addr_read_ready) begin
                        arvalid_d = 1'b0;
                        rready_d  = 1'b1;
                        state_d   = DATA;
                    end else begin
                        arvalid_d = 1'b1;
                    end
                end else begin
                    // The FIFO must have room before a read is issued. The word then
                    // lands unconditionally, so DATA never stalls on fifo_full.
                    if (!fifo_full) begin
                        arvalid_d = 1'b1;
                    end else begin
                        arvalid_d = 1'b0;
                    end
                end
            end

            DATA: begin
                if (data_read_valid) begin
                    wr_en_d     = 1'b1;
                    wr_data_d   = read_data;
                    read_addr_d = read_addr_q + 32'd4;
                    word_d      = word_q + 7'd1;
                    rready_d    = 1'b0;
                    if (word_q == LAST_WORD) begin
                        state_d = BLK_CHECK;
                    end else begin
                        state_d = ADDR;
                    end
                end else begin
                    rready_d = 1'b1;
                end
            end

            BLK_CHECK: begin
                total_blk_d = total_inc_s;
                bnd_blk_d   = bnd_inc_s;
                word_d      = 7'd0;
                if (cnt_ena_q && (total_inc_s >= blk_cnt_q)) begin
                    state_d = COMPLETE;
                    cc_d    = 1'b1;
                end else if (bnd_inc_s == bound_q) begin
                    state_d = NEW_SYS_ADDR;
                end else begin
                    state_d = ADDR;
                end
            end

            NEW_SYS_ADDR: begin
                if (sys_addr_changed) begin
                    read_addr_d = init_dma_sys_addr;
                    bnd_blk_d   = 11'd0;
                    state_d     = ADDR;
                end else begin
                    state_d = NEW_SYS_ADDR;
                end
            end

            COMPLETE: begin
                // A start that arrives together with the clear is dropped
                if (dat_int_rst) begin
                    cc_d    = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = COMPLETE;
                end
            end

            default: begin
                state_d   = IDLE;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                cc_d      = 1'b0;
            end
        endcase
    end

    // Sequencer state and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            read_addr_q <= 32'd0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= 32'd0;
            cc_q        <= 1'b0;
            word_q      <= 7'd0;
            total_blk_q <= 16'd0;
            bnd_blk_q   <= 11'd0;
            bound_q     <= 11'd0;
            blk_cnt_q   <= 16'd0;
            cnt_ena_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            read_addr_q <= read_addr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            cc_q        <= cc_d;
            word_q      <= word_d;
            total_blk_q <= total_blk_d;
            bnd_blk_q   <= bnd_blk_d;
            bound_q     <= bound_d;
            blk_cnt_q   <= blk_cnt_d;
            cnt_ena_q   <= cnt_ena_d;
        end
    end

`ifdef SD_DMA_BOUNDARY_INT_EN
    logic dma_int_q, dma_int_d;

    // Boundary interrupt: set on entry to the boundary stop, cleared by the resume pulse
    always_comb begin
        dma_int_d = dma_int_q;
        if ((state_q == BLK_CHECK) && (state_d == NEW_SYS_ADDR)) begin
            dma_int_d = 1'b1;
        end else if ((state_q == NEW_SYS_ADDR) && sys_addr_changed) begin
            dma_int_d = 1'b0;
        end else begin
            dma_int_d = dma_int_q;
        end
    end

    // Boundary interrupt register
    always_ff @(posedge clock) begin
        if (reset) begin
            dma_int_q <= 1'b0;
        end else begin
            dma_int_q <= dma_int_d;
        end
    end

    assign dma_int = dma_int_q;
`else
    assign dma_int = 1'b0;
`endif

    assign read_addr       = read_addr_q;
    assign addr_read_valid = arvalid_q;
    assign data_read_ready = rready_q;
    assign fifo_wr_en      = wr_en_q;
    assign fifo_wr_data    = wr_data_q;
    assign data_int_cc     = cc_q;

endmodule

// File: tb/tb_sd_emmc_dma_mem_reader.sv
// -----------------------------------------------------------------------------
// tb_sd_emmc_dma_mem_reader
// Randomized bench for the DMA memory reader. The expected address stream of a
// transfer comes from the block/boundary arithmetic: segment base plus word
// offset, with a new base after every 'bound' blocks. A small AXI slave returns
// random data. Every returned beat must reappear, in order, on the FIFO port.
// -----------------------------------------------------------------------------
module tb_sd_emmc_dma_mem_reader;

`ifdef SD_DMA_BOUNDARY_INT_EN
    localparam logic EXP_DMA = 1'b1;
`else
    localparam logic EXP_DMA = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic [31:0] init_dma_sys_addr;
    logic [2:0]  buf_boundary;
    logic [15:0] block_count;
    logic        sys_addr_changed, dma_ena_trans_mode, dir_dat_trans_mode;
    logic        blk_count_ena, xfer_start, dat_int_rst;
    logic        data_int_cc, dma_int, fifo_full, fifo_wr_en;
    logic [31:0] fifo_wr_data, read_addr, read_data;
    logic        addr_read_valid, addr_read_ready, data_read_valid, data_read_ready;

    sd_emmc_dma_mem_reader dut (
        .clock(clock), .reset(reset),
        .init_dma_sys_addr(init_dma_sys_addr), .buf_boundary(buf_boundary),
        .block_count(block_count), .sys_addr_changed(sys_addr_changed),
        .dma_ena_trans_mode(dma_ena_trans_mode), .dir_dat_trans_mode(dir_dat_trans_mode),
        .blk_count_ena(blk_count_ena), .xfer_start(xfer_start), .dat_int_rst(dat_int_rst),
        .data_int_cc(data_int_cc), .dma_int(dma_int),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .read_addr(read_addr), .addr_read_valid(addr_read_valid), .addr_read_ready(addr_read_ready),
        .read_data(read_data), .data_read_valid(data_read_valid), .data_read_ready(data_read_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] seg_base [0:15];
    int wr_cnt  = 0;
    int arv_cnt = 0;
    int ready_pct = 100;
    int full_pct  = 0;

    // AXI slave, FIFO monitor and protocol observer. It runs just after each
    // falling edge and predicts the handshakes of the next rising edge.
    bit          in_flight = 1'b0, pred_a = 1'b0, pred_d = 1'b0;
    bit          prev_rst = 1'b1, prev_valid = 1'b0, prev_ready = 1'b0, prev_full = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    int          delay = 0;

    initial begin : bus_model
        addr_read_ready = 1'b0; data_read_valid = 1'b0; read_data = 32'd0; fifo_full = 1'b0;
        forever begin
            @(negedge clock); #1;
            if (prev_rst) begin
                in_flight = 1'b0; data_read_valid = 1'b0;
            end else begin
                if (pred_d) begin in_flight = 1'b0; data_read_valid = 1'b0; end
                if (pred_a) begin in_flight = 1'b1; delay = $urandom_range(0, 2); end
            end
            if (fifo_wr_en) begin
                wr_cnt++;
                if (exp_data_q.size() == 0) check_eq("fifo_wr_without_beat", 32'(exp_data_q.size()), 32'd1);
                else check_eq("fifo_wr_data", fifo_wr_data, exp_data_q.pop_front());
            end
            if (!prev_rst && addr_read_valid && !prev_valid)
                check_eq("arvalid_rise_while_full", 32'(prev_full), 32'd0);
            if (!prev_rst && prev_valid && !prev_ready) begin
                check_eq("arvalid_hold", 32'(addr_read_valid), 32'd1);
                check_eq("araddr_hold", read_addr, prev_addr);
            end
            if (addr_read_valid) arv_cnt++;
            addr_read_ready = ($urandom_range(0, 99) < ready_pct);
            fifo_full       = ($urandom_range(0, 99) < full_pct);
            if (in_flight && !data_read_valid) begin
                if (delay == 0) begin data_read_valid = 1'b1; read_data = $urandom; end
                else delay--;
            end
            pred_a = addr_read_valid && addr_read_ready && !reset;
            pred_d = data_read_valid && data_read_ready && !reset;
            if (pred_a) begin
                if (exp_addr_q.size() == 0) check_eq("araddr_unexpected", 32'(exp_addr_q.size()), 32'd1);
                else check_eq("araddr", read_addr, exp_addr_q.pop_front());
            end
            if (pred_d) exp_data_q.push_back(read_data);
            prev_rst = reset; prev_valid = addr_read_valid; prev_ready = addr_read_ready;
            prev_full = fifo_full; prev_addr = read_addr;
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    // Expected address stream: block k lives in segment k/bound at offset (k%bound)*512
    task automatic build_model(input logic [31:0] a, input int nblk, input int bound);
        seg_base[0] = a;
        exp_addr_q.delete();
        exp_data_q.delete();
        wr_cnt = 0;
        for (int k = 0; k < nblk; k++)
            for (int w = 0; w < 128; w++)
                exp_addr_q.push_back(seg_base[k / bound] + 32'(((k % bound) * 128 + w) * 4));
    endtask

    task automatic start_xfer(input logic [31:0] a, input logic [15:0] nblk, input logic ena,
                              input logic [2:0] code, input logic dma, input logic dir);
        init_dma_sys_addr = a; block_count = nblk; blk_count_ena = ena; buf_boundary = code;
        dma_ena_trans_mode = dma; dir_dat_trans_mode = dir; xfer_start = 1'b1;
        tick();
        xfer_start = 1'b0;
        // Scramble the mode inputs; they must have been captured at start
        init_dma_sys_addr = $urandom; block_count = 16'($urandom); buf_boundary = 3'($urandom);
        blk_count_ena = 1'($urandom); dma_ena_trans_mode = 1'($urandom); dir_dat_trans_mode = 1'($urandom);
    endtask

    task automatic wait_words(input int target);
        int budget;
        budget = (target - wr_cnt) * 40 + 100;
        for (int i = 0; i < budget && wr_cnt < target; i++) tick();
        check_eq("words_reached", 32'(wr_cnt), 32'(target));
    endtask

    task automatic wait_cc();
        for (int i = 0; i < 200 && !data_int_cc; i++) tick();
        check_eq("cc_set", 32'(data_int_cc), 32'd1);
    endtask

    task automatic finish_xfer(input int nblk, input int bound);
        int segs, target;
        segs = (nblk + bound - 1) / bound;
        for (int s = 0; s < segs; s++) begin
            target = (((s + 1) * bound < nblk) ? (s + 1) * bound : nblk) * 128;
            wait_words(target);
            if (s < segs - 1) begin
                repeat (3) tick();
                check_eq("bstop_arvalid", 32'(addr_read_valid), 32'd0);
                check_eq("bstop_cc", 32'(data_int_cc), 32'd0);
                check_eq("bstop_dma_int", 32'(dma_int), 32'(EXP_DMA));
                init_dma_sys_addr = seg_base[s + 1]; sys_addr_changed = 1'b1;
                tick();
                sys_addr_changed = 1'b0; init_dma_sys_addr = $urandom;
                check_eq("dma_int_clear", 32'(dma_int), 32'd0);
            end
        end
        wait_cc();
        check_eq("words_total", 32'(wr_cnt), 32'(nblk * 128));
        check_eq("addr_left", 32'(exp_addr_q.size()), 32'd0);
        check_eq("data_left", 32'(exp_data_q.size()), 32'd0);
    endtask

    // Clear completion with a valid-looking start in the same cycle; the start must be dropped
    task automatic clear_cc();
        full_pct = 0;
        dat_int_rst = 1'b1; xfer_start = 1'b1; dma_ena_trans_mode = 1'b1; dir_dat_trans_mode = 1'b0;
        blk_count_ena = 1'b1; block_count = 16'd1;
        tick();
        dat_int_rst = 1'b0; xfer_start = 1'b0; arv_cnt = 0;
        repeat (6) tick();
        check_eq("cc_cleared", 32'(data_int_cc), 32'd0);
        check_eq("start_with_clear_ignored", 32'(arv_cnt), 32'd0);
    endtask

    task automatic run_xfer(input logic [31:0] a, input int nblk, input logic [2:0] code);
        build_model(a, nblk, 8 << code);
        start_xfer(a, 16'(nblk), 1'b1, code, 1'b1, 1'b0);
        finish_xfer(nblk, 8 << code);
        clear_cc();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        check_eq("rst_read_addr", read_addr, 32'd0);
        check_eq("rst_fifo_wr_data", fifo_wr_data, 32'd0);
        check_eq("rst_arvalid", 32'(addr_read_valid), 32'd0);
        check_eq("rst_rready", 32'(data_read_ready), 32'd0);
        check_eq("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        check_eq("rst_cc", 32'(data_int_cc), 32'd0);
        check_eq("rst_dma_int", 32'(dma_int), 32'd0);
        reset = 1'b0;
        exp_addr_q.delete(); exp_data_q.delete(); wr_cnt = 0;
    endtask

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] a;
        int          nb;
        reset = 1'b1; init_dma_sys_addr = 32'd0; buf_boundary = 3'd0; block_count = 16'd0;
        sys_addr_changed = 1'b0; dma_ena_trans_mode = 1'b0; dir_dat_trans_mode = 1'b0;
        blk_count_ena = 1'b0; xfer_start = 1'b0; dat_int_rst = 1'b0;
        repeat (2) tick();
        do_reset();

        // Wrong direction and DMA disabled: start ignored, nothing latched
        for (int c = 0; c < 2; c++) begin
            arv_cnt = 0;
            start_xfer(32'hDEAD_BEE0, 16'd1, 1'b1, 3'd0, (c == 0), (c == 0));
            repeat (8) tick();
            check_eq("bad_start_arvalid", 32'(arv_cnt), 32'd0);
            check_eq("bad_start_addr", read_addr, 32'd0);
            check_eq("bad_start_cc", 32'(data_int_cc), 32'd0);
        end

        // Single block, always-ready slave
        ready_pct = 100; full_pct = 0;
        run_xfer(32'h1000_0000, 1, 3'd0);

        // Boundary stop after 8 blocks, resume at 0x2000_0000 for the last 2
        seg_base[1] = 32'h2000_0000;
        run_xfer(32'h1000_0000, 10, 3'd0);

        // Zero block count: completes without any read
        arv_cnt = 0;
        start_xfer(32'h7000_0000, 16'd0, 1'b1, 3'd2, 1'b1, 1'b0);
        wait_cc();
        check_eq("zero_cnt_arvalid", 32'(arv_cnt), 32'd0);
        clear_cc();

        // FIFO backpressure for 20 cycles, then AXI address stall for 5 cycles
        ready_pct = 0; full_pct = 100;
        build_model(32'h4000_0000, 1, 8);
        start_xfer(32'h4000_0000, 16'd1, 1'b1, 3'd0, 1'b1, 1'b0);
        repeat (20) begin
            tick();
            check_eq("bp_arvalid_low", 32'(addr_read_valid), 32'd0);
        end
        full_pct = 0;
        tick();
        check_eq("bp_resume", 32'(addr_read_valid), 32'd1);
        check_eq("bp_first_addr", read_addr, 32'h4000_0000);
        repeat (5) begin
            tick();
            check_eq("stall_arvalid", 32'(addr_read_valid), 32'd1);
            check_eq("stall_addr", read_addr, 32'h4000_0000);
        end
        ready_pct = 100;
        finish_xfer(1, 8);
        clear_cc();

        // Reset at word 64 of the second block, then a clean restart
        build_model(32'h5000_0100, 3, 8);
        start_xfer(32'h5000_0100, 16'd3, 1'b1, 3'd0, 1'b1, 1'b0);
        wait_words(192);
        do_reset();
        run_xfer(32'h5000_0100, 1, 3'd0);

        // Endless mode ignores block_count; stopped only by reset
        build_model(32'h6000_0000, 3, 8);
        start_xfer(32'h6000_0000, 16'd1, 1'b0, 3'd0, 1'b1, 1'b0);
        wait_words(256);
        check_eq("endless_no_cc", 32'(data_int_cc), 32'd0);
        do_reset();

        // Random short transfers under random backpressure, one wrapping past 2^32
        for (int t = 0; t < 3; t++) begin
            ready_pct = $urandom_range(30, 100); full_pct = $urandom_range(0, 50);
            a  = (t == 0) ? 32'hFFFF_FF00 : ($urandom & 32'hFFFF_FFFC);
            nb = $urandom_range(1, 3);
            run_xfer(a, nb, 3'($urandom_range(0, 7)));
        end

        // Random boundary-crossing transfer
        ready_pct = $urandom_range(40, 100); full_pct = $urandom_range(0, 30);
        for (int s = 1; s < 16; s++) seg_base[s] = $urandom & 32'hFFFF_FFFC;
        run_xfer($urandom & 32'hFFFF_FFFC, $urandom_range(9, 12), 3'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_emmc_dma_mem_reader.md
SD_EMMC_DMA_MEM_READER -- requirements
Module: sd_emmc_dma_mem_reader

Interface
REQ-001 SHALL provide ports: clock  in  1  sole clock; all logic on its rising edge.
REQ-002 SHALL provide ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL provide control inputs: init_dma_sys_addr in 32 start address; buf_boundary in 3 boundary code; block_count in 16 blocks to send; sys_addr_changed in 1 pulse, new address written; dma_ena_trans_mode in 1; dir_dat_trans_mode in 1 (0 = host-to-card); blk_count_ena in 1; xfer_start in 1 pulse, start transfer; dat_int_rst in 1 pulse, clear completion.
REQ-004 SHALL provide status outputs: data_int_cc out 1 transfer complete; dma_int out 1 boundary-stop interrupt.
REQ-005 SHALL provide TX FIFO ports: fifo_full in 1; fifo_wr_en out 1; fifo_wr_data out 32.
REQ-006 SHALL provide M_AXI read ports: read_addr out 32; addr_read_valid out 1; addr_read_ready in 1; read_data in 32; data_read_valid in 1; data_read_ready out 1.

Function
REQ-007 SHALL use states IDLE, ADDR, DATA, BLK_CHECK, NEW_SYS_ADDR, COMPLETE; a block SHALL be 128 32-bit words (512 bytes); every AXI read SHALL be one 4-byte single-beat transaction.
REQ-008 IDLE: when xfer_start & dma_ena_trans_mode & ~dir_dat_trans_mode, SHALL latch read_addr <= init_dma_sys_addr, clear word/block counters, go to ADDR; other xfer_start SHALL be ignored. Mode inputs SHALL NOT be sampled again after start.
REQ-009 IDLE, blk_count_ena=1 and block_count=0 at start: SHALL go directly to COMPLETE with no AXI access.
REQ-010 ADDR: SHALL assert addr_read_valid only while fifo_full=0; once asserted, SHALL hold it and read_addr stable until addr_read_ready=1 in the same cycle; next cycle deassert, go to DATA.
REQ-011 DATA: SHALL hold data_read_ready=1; on data_read_valid=1, SHALL drive fifo_wr_data <= read_data and fifo_wr_en=1 for exactly one cycle (write follows the beat by one clock), read_addr += 4 (mod 2^32), word counter +1; go to BLK_CHECK if the word just taken was word 127, else ADDR.
REQ-012 BLK_CHECK (one cycle): total_blk +1, boundary_blk +1; if blk_count_ena and total_blk (new) >= block_count -> COMPLETE; else if boundary_blk (new) == bound -> NEW_SYS_ADDR; else ADDR with word counter 0.
REQ-013 Boundary bound in blocks SHALL be 8 << buf_boundary (code 0 = 4 KB = 8 blocks ... code 7 = 512 KB = 1024 blocks), sampled at xfer_start.
REQ-014 NEW_SYS_ADDR: SHALL wait for sys_addr_changed; then read_addr <= init_dma_sys_addr, boundary_blk <= 0, go to ADDR.
REQ-015 blk_count_ena=0: transfer SHALL be endless, ending only by reset.
REQ-016 COMPLETE: data_int_cc=1; on dat_int_rst SHALL clear data_int_cc, return to IDLE; simultaneous xfer_start SHALL be ignored that cycle.
REQ-017 Counters: word 7-bit, total_blk 16-bit, boundary_blk 11-bit; none SHALL wrap within a legal transfer.
REQ-018 fifo_full during DATA SHALL NOT stall acceptance (space was checked at ADDR); exactly one word in flight at any time.

Reset
REQ-019 On reset=1 at a clock edge, state SHALL go to IDLE and all outputs SHALL be 0 (read_addr 0, fifo_wr_data 0, all valid/ready/interrupt/wr_en 0), all counters 0.
REQ-020 Reset mid-transaction SHALL abort immediately; outstanding AXI beat is dropped, no FIFO write issued.

Configuration
REQ-021 Macro SD_DMA_BOUNDARY_INT_EN: defined -> dma_int SHALL rise on entry to NEW_SYS_ADDR and clear the cycle after sys_addr_changed; undefined -> dma_int SHALL be constant 0, NEW_SYS_ADDR behaviour otherwise unchanged.

Verification
REQ-022 Single block: addr 0x1000_0000, block_count 1, blk_count_ena 1, ready always 1 -> 128 reads 0x1000_0000..0x1000_01FC, 128 fifo_wr_en pulses in order, data_int_cc=1.
REQ-023 Boundary: buf_boundary 0, block_count 10 -> stop after 8 blocks, dma_int=1 (macro defined); sys_addr_changed with addr 0x2000_0000 -> remaining 2 blocks from 0x2000_0000, then data_int_cc.
REQ-024 Backpressure: fifo_full=1 for 20 cycles while in ADDR -> addr_read_valid stays 0; resumes within 1 cycle of fifo_full=0, no word lost.
REQ-025 AXI stall: addr_read_ready low 5 cycles -> addr_read_valid and read_addr held constant throughout.
REQ-026 Zero count / wrong direction: block_count 0 -> data_int_cc with no addr_read_valid; dir_dat_trans_mode=1 with xfer_start -> stays IDLE.
REQ-027 Reset at word 64 of block 2 -> all outputs 0 next cycle; new start re-reads from init_dma_sys_addr.
